// File: rtl/driver_sequencer.sv
// Bit-plane stream to LED-driver serial sequencer: SIN/SCLK-enable/LAT generation with sync tracking.
// Optional misaligned-sync counter is built when DRIVER_SEQ_STATS_EN is defined.
module driver_sequencer #(
    parameter int POKER_MODE      = 9,
    parameter int BLANKING_CYCLES = 72,
    parameter int GROUP_BITS      = 48,
    parameter int WRTGS_LEN       = 1,
    parameter int LATGS_LEN       = 3
) (
    input  logic        clk_33,
    input  logic        nrst,
    input  logic [29:0] data_in,
    input  logic        sync_in,
    output logic [29:0] sout,
    output logic        sclk_en,
    output logic        lat,
    output logic        seg_start,
    output logic        sync_err,
    output logic [7:0]  sync_err_cnt
);

    localparam int SEGMENT_CYCLES = BLANKING_CYCLES + POKER_MODE * (GROUP_BITS + 1);
    localparam int CYC_W          = $clog2(SEGMENT_CYCLES + 1);
    localparam int BIT_W          = $clog2(GROUP_BITS + 1);
    localparam int GRP_W          = $clog2(POKER_MODE + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        BLANK     = 2'd1,
        SHIFT     = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             r_state;
    logic [CYC_W-1:0]   r_cyc_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GRP_W-1:0]   r_grp_cnt;

    logic               w_last_grp;
    logic               w_lat;
    logic               w_seg_end;
    logic               w_sync_err;

    assign w_last_grp = (r_grp_cnt == GRP_W'(POKER_MODE - 1));
    // Final group holds LAT longer (LATGS) than the intermediate groups (WRTGS).
    assign w_lat      = w_last_grp ? (r_bit_cnt >= BIT_W'(GROUP_BITS - LATGS_LEN))
                                   : (r_bit_cnt >= BIT_W'(GROUP_BITS - WRTGS_LEN));
    assign w_seg_end  = (r_cyc_cnt == CYC_W'(SEGMENT_CYCLES - 1));
    assign w_sync_err = sync_in && (r_state != WAIT_SYNC) && !w_seg_end;

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_state   <= WAIT_SYNC;
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_grp_cnt <= '0;
            sout      <= '0;
            sclk_en   <= 1'b0;
            lat       <= 1'b0;
            seg_start <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sout      <= '0;
            sclk_en   <= 1'b0;
            lat       <= 1'b0;
            seg_start <= (r_state == BLANK) && (r_cyc_cnt == '0);

            if (r_state == WAIT_SYNC) begin
                if (sync_in) begin
                    r_state   <= BLANK;
                    r_cyc_cnt <= '0;
                end
            end else if (w_sync_err) begin
                // Abort whatever was in flight; this cycle produces no output bit or LAT.
                sync_err  <= 1'b1;
                r_state   <= BLANK;
                r_cyc_cnt <= '0;
            end else begin
                r_cyc_cnt <= w_seg_end ? '0 : r_cyc_cnt + CYC_W'(1);
                case (r_state)
                    BLANK: begin
                        if (r_cyc_cnt == CYC_W'(BLANKING_CYCLES - 1)) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= '0;
                            r_grp_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        sout    <= data_in;
                        sclk_en <= 1'b1;
                        lat     <= w_lat;
                        if (r_bit_cnt == BIT_W'(GROUP_BITS - 1)) begin
                            r_state <= GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                    GAP: begin
                        r_bit_cnt <= '0;
                        if (!w_last_grp) begin
                            r_grp_cnt <= r_grp_cnt + GRP_W'(1);
                            r_state   <= SHIFT;
                        end else begin
                            r_state <= BLANK;
                        end
                    end
                    default: r_state <= WAIT_SYNC;
                endcase
            end
        end
    end

`ifdef DRIVER_SEQ_STATS_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_err_cnt <= '0;
        end else if (w_sync_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign sync_err_cnt = r_err_cnt;
`else
    assign sync_err_cnt = '0;
`endif

endmodule

// File: tb/tb_driver_sequencer.sv
// Directed bench for driver_sequencer: a position-based timing model checks every cycle,
// plus hand-computed spot checks on reset, latency, lat counts, sync errors and mid-shift reset.
module tb_driver_sequencer;

    logic        clk_33;
    logic        nrst;
    logic [29:0] data_in;
    logic        sync_in;
    logic [29:0] sout;
    logic        sclk_en;
    logic        lat;
    logic        seg_start;
    logic        sync_err;
    logic [7:0]  sync_err_cnt;

    driver_sequencer dut (
        .clk_33       (clk_33),
        .nrst         (nrst),
        .data_in      (data_in),
        .sync_in      (sync_in),
        .sout         (sout),
        .sclk_en      (sclk_en),
        .lat          (lat),
        .seg_start    (seg_start),
        .sync_err     (sync_err),
        .sync_err_cnt (sync_err_cnt)
    );

    initial clk_33 = 1'b0;
    always #15 clk_33 = ~clk_33;

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc_now;
    int          t_sync;
    logic [29:0] prev_data;
    int          mism_sclk, mism_lat, mism_sout, mism_seg;
    int          sclk_cnt, lat_cnt, seg_cnt;
    int          t_ref;
    logic [7:0]  exp_err_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_now);
    endtask

    task automatic clear_stats();
        mism_sclk = 0; mism_lat = 0; mism_sout = 0; mism_seg = 0;
        sclk_cnt  = 0; lat_cnt  = 0; seg_cnt   = 0;
    endtask

    // Compare this cycle's outputs against the segment-position model, then drive the next inputs.
    task automatic step(input logic s, input logic [29:0] d);
        int k, q, b, g;
        logic e_sclk, e_lat, e_seg;
        logic [29:0] e_sout;
        e_sclk = 1'b0; e_lat = 1'b0; e_seg = 1'b0; e_sout = '0;
        if (t_sync >= 0) begin
            k = (cyc_now - 1) - t_sync;
            if (k >= 1) begin
                q = (k - 1) % 513;
                e_seg = (q == 0);
                if (q >= 72) begin
                    g = (q - 72) / 49;
                    b = (q - 72) % 49;
                    if (b < 48) begin
                        e_sclk = 1'b1;
                        e_sout = prev_data;
                        e_lat  = (g < 8) ? (b == 47) : (b >= 45);
                    end
                end
            end
        end
        if (sclk_en !== e_sclk)  mism_sclk++;
        if (lat !== e_lat)       mism_lat++;
        if (sout !== e_sout)     mism_sout++;
        if (seg_start !== e_seg) mism_seg++;
        if (sclk_en === 1'b1)   sclk_cnt++;
        if (lat === 1'b1)       lat_cnt++;
        if (seg_start === 1'b1) seg_cnt++;
        sync_in   = s;
        data_in   = d;
        prev_data = d;
        if (s) t_sync = cyc_now;
        @(posedge clk_33);
        #1;
        cyc_now++;
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_sclk_model"}, mism_sclk, 0);
        check_val({tag, "_lat_model"},  mism_lat,  0);
        check_val({tag, "_sout_model"}, mism_sout, 0);
        check_val({tag, "_seg_model"},  mism_seg,  0);
    endtask

    function automatic logic [29:0] alt_data(input int c);
        return c[0] ? 30'h3FFFFFFF : 30'h0;
    endfunction

    initial begin
`ifdef DRIVER_SEQ_STATS_EN
        exp_err_cnt = 8'd1;
`else
        exp_err_cnt = 8'd0;
`endif
        nrst = 1'b0; sync_in = 1'b0; data_in = '0; prev_data = '0;
        cyc_now = 0; t_sync = -1;
        clear_stats();
        #5;
        check_val("rst_sout",      sout,         0);
        check_val("rst_sclk_en",   sclk_en,      0);
        check_val("rst_lat",       lat,          0);
        check_val("rst_seg_start", seg_start,    0);
        check_val("rst_sync_err",  sync_err,     0);
        check_val("rst_err_cnt",   sync_err_cnt, 0);
        @(posedge clk_33);
        #1;
        nrst = 1'b1;

        // No sync: must stay idle regardless of data_in.
        for (int i = 0; i < 2000; i++) step(1'b0, 30'($urandom()));
        check_val("idle_sclk_cnt", sclk_cnt, 0);
        check_val("idle_lat_cnt",  lat_cnt,  0);
        check_model("idle");

        // First sync, then eight free-running segments with alternating data.
        clear_stats();
        step(1'b1, alt_data(cyc_now));
        t_ref = t_sync;
        check_val("seg_start_t1", seg_start, 0);
        step(1'b0, alt_data(cyc_now));
        check_val("seg_start_t2", seg_start, 1);
        while (cyc_now < t_ref + 73) step(1'b0, alt_data(cyc_now));
        check_val("sclk_en_t73", sclk_en, 0);
        step(1'b0, alt_data(cyc_now));
        check_val("sclk_en_t74", sclk_en, 1);
        while (cyc_now < t_ref + 8 * 513) step(1'b0, alt_data(cyc_now));
        step(1'b1, alt_data(cyc_now));
        check_val("aligned_sync_err", sync_err, 0);
        check_val("run8_sclk_cnt", sclk_cnt, 8 * 432);
        check_val("run8_lat_cnt",  lat_cnt,  8 * 11);
        check_val("run8_seg_cnt",  seg_cnt,  8);
        check_model("run8");

        // Sync 10 cycles early (segment position 502, mid final group).
        t_ref = t_sync;
        while (cyc_now < t_ref + 503) step(1'b0, 30'($urandom()));
        check_val("pre_abort_sclk", sclk_en, 1);
        step(1'b1, 30'($urandom()));
        t_ref = t_sync;
        check_val("abort_sclk_drop", sclk_en, 0);
        check_val("abort_lat",       lat,     0);
        check_val("early_sync_err",  sync_err, 1);
        check_val("early_err_cnt",   sync_err_cnt, exp_err_cnt);
        check_model("pre_abort");
        clear_stats();
        while (cyc_now < t_ref + 514) step(1'b0, 30'($urandom()));
        check_val("realign_sclk_cnt", sclk_cnt, 432);
        check_val("realign_lat_cnt",  lat_cnt,  11);
        check_val("realign_seg_cnt",  seg_cnt,  1);
        check_val("sticky_sync_err",  sync_err, 1);
        check_model("realign");

        // Asynchronous reset in the middle of a SHIFT run.
        while (cyc_now < t_ref + 614) step(1'b0, 30'h3FFFFFFF);
        check_val("pre_rst_sclk", sclk_en, 1);
        #3;
        nrst = 1'b0;
        #1;
        check_val("arst_sout",     sout,         0);
        check_val("arst_sclk_en",  sclk_en,      0);
        check_val("arst_sync_err", sync_err,     0);
        check_val("arst_err_cnt",  sync_err_cnt, 0);
        @(posedge clk_33);
        #1;
        nrst = 1'b1;
        cyc_now++;
        t_sync = -1;
        clear_stats();
        for (int i = 0; i < 200; i++) step(1'b0, 30'($urandom()));
        check_val("post_rst_idle_sclk", sclk_cnt, 0);
        step(1'b1, 30'($urandom()));
        step(1'b0, 30'($urandom()));
        check_val("post_rst_seg_start", seg_start, 1);
        for (int i = 0; i < 120; i++) step(1'b0, 30'($urandom()));
        check_model("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/driver_sequencer.md
Name: driver_sequencer

Overview:
- Consumes the 30-lane bit-plane stream (data + sync) from the framebuffer/emulator stage and produces LED-driver serial-side signals: per-lane SIN, SCLK enable and LAT.
- Tracks segment timing: blanking, then POKER_MODE groups of GROUP_BITS data cycles, each group followed by 1 gap cycle.
- Generates WRTGS/LATGS latch pulses and flags sync misalignment.
- Sits between the stream source and the pad-level driver interface.

Parameters:
- POKER_MODE, 9: groups (bit planes) per segment.
- BLANKING_CYCLES, 72: idle cycles at start of each segment.
- GROUP_BITS, 48: data cycles per group (16 LEDs x 3 colours).
- WRTGS_LEN, 1: LAT high cycles at end of a non-final group.
- LATGS_LEN, 3: LAT high cycles at end of the final group of a segment.
- SEGMENT_CYCLES, BLANKING_CYCLES+POKER_MODE*(GROUP_BITS+1) = 513: segment length.

Ports:
- clk_33 in 1: system clock, 33 MHz.
- nrst in 1: asynchronous active-low reset.
- data_in in 30: one bit per driver lane, valid during data cycles.
- sync_in in 1: 1-cycle pulse on the last cycle of a segment; the next cycle is segment cycle 0.
- sout out 30: registered serial data to the drivers (SIN).
- sclk_en out 1: high when sout carries a valid bit; gates SCLK.
- lat out 1: driver LAT, aligned to sout.
- seg_start out 1: 1-cycle pulse on segment cycle 0.
- sync_err out 1: sticky; set on misaligned sync, cleared by reset only.
- sync_err_cnt out 8: see Optional Feature.

Behaviour:
- Reset values: sout=0, sclk_en=0, lat=0, seg_start=0, sync_err=0, sync_err_cnt=0; FSM in WAIT_SYNC.
- FSM states: WAIT_SYNC, BLANK, SHIFT, GAP.
- Internal counters: cyc_cnt 0..SEGMENT_CYCLES-1, bit_cnt 0..GROUP_BITS-1, grp_cnt 0..POKER_MODE-1.
- WAIT_SYNC: outputs idle. On sync_in go to BLANK with cyc_cnt=0. data_in is ignored before the first sync.
- BLANK: lasts BLANKING_CYCLES cycles, then SHIFT with bit_cnt=0, grp_cnt=0.
- SHIFT: capture data_in each cycle. After bit GROUP_BITS-1, go to GAP.
- GAP: lasts 1 cycle, data_in ignored.
  - If grp_cnt<POKER_MODE-1: grp_cnt+1, then SHIFT.
  - Otherwise: segment ends, cyc_cnt wraps to 0, then BLANK. Free-runs without further sync.
- Latency 1 cycle: sout(t+1)=data_in(t) for SHIFT cycles; otherwise sout holds 0. sclk_en(t+1)=1 iff cycle t was SHIFT.
- lat(t+1)=1 when cycle t is SHIFT and either:
  - grp_cnt<POKER_MODE-1 and bit_cnt>=GROUP_BITS-WRTGS_LEN, or
  - grp_cnt==POKER_MODE-1 and bit_cnt>=GROUP_BITS-LATGS_LEN.
  - lat is 0 in all other cycles, so LAT always falls before the gap cycle.
- seg_start is registered: high in the cycle after the FSM enters cycle 0 of a segment.
- Sync check:
  - sync_in while cyc_cnt==SEGMENT_CYCLES-1: no action.
  - sync_in at any other cyc_cnt (outside WAIT_SYNC): set sync_err, abort the current group, force BLANK with cyc_cnt=0 next cycle.
  - An aborted group drives no lat pulse; sclk_en drops next cycle.
- sync_in in the same cycle as a natural wrap is aligned, not an error.
- Async reset mid-group: all outputs return to 0 immediately; FSM returns to WAIT_SYNC.

Optional Feature:
- Macro DRIVER_SEQ_STATS_EN.
- Defined: sync_err_cnt increments on each misaligned sync and saturates at 255.
- Undefined: no counter logic; sync_err_cnt tied to 0.
- sync_err is unaffected either way.

Test Plan:
- Reset, then no sync for 2000 cycles -> sclk_en, lat, sout remain 0.
- sync_in at T -> seg_start at T+2; first sclk_en at T+74; sclk_en high 48 cycles then low 1, repeated 9 times; segment length 513.
- data_in=30'h3FFFFFFF alternating with 0 each cycle -> sout mirrors with 1-cycle delay in SHIFT, 0 in BLANK/GAP.
- Count lat per segment -> groups 0..7 one cycle each coincident with bit 47; group 8 three cycles on bits 45..47.
- Aligned sync every 8 segments -> sync_err=0. Sync 10 cycles early -> sync_err=1, realign, next segment timing correct, sync_err_cnt=1 (with macro).
- Assert nrst low mid-SHIFT -> outputs 0 asynchronously; after release, idle until the next sync.
